// File: rtl/nfu2_psum_accum_pkg.sv
// Shared definitions for the NFU-2 partial-sum accumulator: default widths,
// FSM state encoding and saturation limits.
package nfu_pkg;

  localparam int N_DEFAULT     = 16;
  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Two's-complement limits of an N_DEFAULT-bit signed value
  localparam logic [N_DEFAULT-1:0] SAT_MAX = {1'b0, {(N_DEFAULT-1){1'b1}}};
  localparam logic [N_DEFAULT-1:0] SAT_MIN = {1'b1, {(N_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/nfu2_psum_accum_if.sv
// Upstream beat and downstream result handshake of the partial-sum accumulator.
// The accumulator takes the slave side; the driving environment takes master.
interface nfu2_psum_accum_if
  import nfu_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
);
  logic             i_valid;
  logic             o_ready;
  logic [N-1:0]     i_psum;
  logic [CNT_W-1:0] i_num_tiles;
  logic             o_valid;
  logic             i_ready;
  logic [N-1:0]     o_res;
  logic             o_sat;

  modport slave (
    input  i_valid, i_psum, i_num_tiles, i_ready,
    output o_ready, o_valid, o_res, o_sat
  );

  modport master (
    output i_valid, i_psum, i_num_tiles, i_ready,
    input  o_ready, o_valid, o_res, o_sat
  );
endinterface

// File: rtl/nfu2_psum_accum_sat_add.sv
// nfu_sat_add: combinational W-bit signed adder that clips to the signed range
// and flags when a clip happened.
module nfu_sat_add
  import nfu_pkg::*;
#(
  parameter int W = N_DEFAULT
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         clipped_o
);
  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  logic [W:0] full;

  // One guard bit: overflow shows up as disagreement between the top two bits
  assign full = {a_i[W-1], a_i} + {b_i[W-1], b_i};

  always_comb begin
    clipped_o = full[W] ^ full[W-1];
    sum_o     = full[W-1:0];
    if (clipped_o) begin
      sum_o = full[W] ? MIN_V : MAX_V;
    end
  end
endmodule

// File: rtl/nfu2_psum_accum.sv
// Accumulates a programmable number of NFU-2 tree sums per output neuron and
// hands the total to NFU-3. Define NFU2_ACC_SAT_EN for saturating adds with o_sat.
module nfu2_psum_accum
  import nfu_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  nfu2_psum_accum_if.slave bus
);
  state_e           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] first_tgt;
  logic [CNT_W-1:0] cnt_inc;
  logic [N-1:0]     sum;
  logic             ready;
  logic             accept;

  assign ready     = (state_q != DONE);
  assign accept    = bus.i_valid && ready;
  assign first_tgt = (bus.i_num_tiles == '0) ? CNT_W'(1) : bus.i_num_tiles;
  assign cnt_inc   = cnt_q + CNT_W'(1);

`ifdef NFU2_ACC_SAT_EN
  logic sat_q, sat_d;
  logic clipped;

  nfu_sat_add #(.W(N)) u_sat_add (
    .a_i       (acc_q),
    .b_i       (bus.i_psum),
    .sum_o     (sum),
    .clipped_o (clipped)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  // Sticky clip flag, restarted by the first beat of each group
  always_comb begin
    sat_d = sat_q;
    if (accept) begin
      if (state_q == IDLE) begin
        sat_d = 1'b0;
      end else begin
        sat_d = sat_q | clipped;
      end
    end
  end

  assign bus.o_sat = sat_q;
`else
  assign sum       = acc_q + bus.i_psum;
  assign bus.o_sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d   = first_tgt;
          acc_d   = bus.i_psum;
          cnt_d   = CNT_W'(1);
          state_d = (first_tgt == CNT_W'(1)) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = sum;
          cnt_d = cnt_inc;
          // Group ends on the compare, so the counter can never wrap
          if (cnt_inc == tgt_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_ready = ready;
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_res   = acc_q;
endmodule

// File: doc/nfu2_psum_accum.md
Name: nfu2_psum_accum

Overview:
- Partial-sum accumulator directly downstream of the NFU-2 adder tree.
- Each valid beat carries one signed N-bit tree sum (one Tn-wide input tile). The block accumulates a programmable number of tiles per output neuron.
- Presents the final neuron sum to NFU-3 through a valid/ready handshake.
- Groups of tiles are processed strictly one at a time.

Parameters:
- N, 16, datapath width in bits; signed two's-complement fixed point.
- CNT_W, 8, width of tile-count config and internal tile counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  i_psum beat valid
- o_ready  output  1  accumulator can accept a beat
- i_psum  input  N  adder-tree sum for one tile
- i_num_tiles  input  CNT_W  tiles per group; sampled only on the first beat of a group
- o_valid  output  1  o_res holds a completed group sum
- i_ready  input  1  downstream accepts o_res
- o_res  output  N  accumulated neuron sum
- o_sat  output  1  at least one clip occurred in this group (valid with o_valid)

Behaviour:
- Reset: asynchronous on rst_n low; all state clears immediately. Values during reset:
  - state = IDLE, o_ready = 1, o_valid = 0, o_res = 0, o_sat = 0
  - accumulator = 0, tile counter = 0, latched count = 0
- Input handshake: a beat is accepted on a rising clk edge with i_valid && o_ready. o_ready is 1 in IDLE and ACCUM and 0 in DONE. It is driven from state only, with no combinational path from i_valid.
- States:
  - IDLE: on accept, latch target = (i_num_tiles == 0) ? 1 : i_num_tiles; acc = i_psum; cnt = 1.
    - If target == 1, go to DONE; otherwise go to ACCUM.
  - ACCUM: on accept, acc = acc + i_psum; cnt = cnt + 1.
    - If cnt + 1 == target, go to DONE.
    - No accept means hold all state; bubbles are allowed.
  - DONE: o_valid = 1; o_res = acc; hold both stable until i_valid... no — until i_ready is sampled high.
    - On o_valid && i_ready, go to IDLE; o_valid = 0 and o_ready = 1 from the next cycle.
- Timing:
  - Latency: last beat accepted at edge k gives o_valid = 1 from edge k (registered), visible in cycle k+1.
  - Minimum group period is target + 1 cycles (one bubble while in DONE).
- i_num_tiles:
  - Changes on i_num_tiles after the first beat of a group have no effect.
  - i_num_tiles == 0 is treated as 1.
  - Maximum target is 2^CNT_W − 1. The counter never wraps because the compare ends the group first.
- Arithmetic: N-bit signed add each beat, wrap or saturate per the Optional Feature. o_sat clears on the first beat of each group.
- Simultaneous events:
  - In DONE, o_ready = 0, so an upstream beat presented together with i_ready stalls one cycle and is accepted in IDLE.
  - i_ready while not in DONE is ignored.
- Reset mid-group: the partial accumulation is discarded. The first beat after reset release starts a new group.

Optional Feature:
- Macro: NFU2_ACC_SAT_EN.
- Defined:
  - Each add clips to [−2^(N−1), 2^(N−1)−1].
  - Any clip sets o_sat sticky for the group.
  - A first-beat value is never clipped.
- Undefined:
  - Modulo-2^N wraparound add.
  - o_sat tied to 0.
  - No saturation logic synthesised.

Decomposition:
- Shared package nfu_pkg:
  - N default
  - State encoding localparams: IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2
  - SAT_MAX and SAT_MIN constants derived from N
- Sub-module nfu_sat_add (a, b → sum, clipped): combinational signed adder with saturation. Instantiated only under NFU2_ACC_SAT_EN.

Test Plan:
- Single tile: i_num_tiles = 1, i_psum = 16'h0123 → o_valid next cycle, o_res = 16'h0123, o_ready = 0 until i_ready.
- Four tiles: sums 10, −3, 7, 1 with i_ready held 1 → o_res = 15 one cycle after the 4th beat; o_ready returns 1 the cycle after the handshake.
- Backpressure and bubbles:
  - i_valid toggling within the group.
  - i_ready low for 5 cycles in DONE.
  - Required: o_res stable and o_valid held; upstream beats not accepted.
- Count corner cases: i_num_tiles = 0 behaves as 1; i_num_tiles changed mid-group has no effect; i_num_tiles = 255 completes after exactly 255 beats.
- Overflow: two beats of 16'h7000.
  - With NFU2_ACC_SAT_EN: o_res = 16'h7FFF, o_sat = 1.
  - Without NFU2_ACC_SAT_EN: o_res = 16'hE000, o_sat = 0.
- Async reset: assert rst_n low mid-edge-free after 2 of 4 beats → outputs clear immediately; a new 2-tile group of 5, 6 afterwards gives o_res = 11.
